comparator_4bit_bf: RTL and testbench
=====================================

Name: comparator_4bit_bf

Overview:
Registered unsigned/signed magnitude comparator for two 4-bit operands, producing one-hot equal / greater / less flags. Comparison logic is a bit-level cascade (MSB-first priority on per-bit xnor equality terms), registered once at the output. Used as a leaf compare stage wherever a clocked E/G/L flag triple is needed.

Parameters:
WIDTH, 4, operand width in bits. Spec and tests are written for 4; logic generalises to any value of 2 or more.
SIGNED_CMP, 0, 0 = unsigned compare; 1 = two's-complement compare.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands A/B valid this cycle; qualifies capture
A  input  WIDTH  operand A
B  input  WIDTH  operand B
out_valid  output  1  E/G/L hold the result of a captured operand pair
E  output  1  A == B
G  output  1  A > B
L  output  1  A < B

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - E = 0, G = 0, L = 0, out_valid = 0 immediately.
  - Values held while rst_n is low.
  - Deassertion is sampled on the next rising clk edge.
- Combinational core:
  - Per-bit equality x[i] = ~(A[i] ^ B[i]).
  - eq = AND of all x[i].
  - gt = OR over i of (A[i] & ~B[i] & AND of x[j] for all j > i), evaluated MSB first.
  - lt = OR over i of (~A[i] & B[i] & AND of x[j] for all j > i).
- SIGNED_CMP = 1: the MSB term of gt/lt is swapped, i.e. A[MSB] = 0 and B[MSB] = 1 means A > B. Lower bits use the same cascade.
- Exactly one of eq/gt/lt is 1 for any input pair.
- Latency: 1 cycle.
  - On a rising clk edge with in_valid = 1: E <= eq, G <= gt, L <= lt, out_valid <= 1.
  - On an edge with in_valid = 0: E/G/L hold their previous values; out_valid <= 0.
- Back-to-back valid inputs: one result per cycle, fully pipelined, no stall.
- After the first valid capture, E/G/L are always one-hot. Before it (post-reset), all three are 0.
- X/Z on A or B while in_valid = 0 has no effect on the outputs.
- Reset asserted mid-stream: outputs clear immediately and any in-flight result is discarded.
- No internal state other than the output registers and out_valid.

Test Plan:
- Reset: drive rst_n low with no clock -> E = G = L = 0 and out_valid = 0 immediately. Release rst_n, hold in_valid = 0 -> outputs remain 0.
- Directed unsigned sequence with in_valid = 1 each cycle, one cycle after each pair:
  - A = 0, B = 0 -> E = 1, G = 0, L = 0.
  - A = 11, B = 7 -> G = 1.
  - A = 13, B = 14 -> L = 1.
  - A = 3, B = 7 -> L = 1.
  - A = 15, B = 13 -> G = 1.
  - out_valid = 1 throughout.
- Hold: capture A = 11, B = 7 (G = 1), then drop in_valid and change A = 2, B = 9 -> G stays 1, out_valid = 0.
- Signed (SIGNED_CMP = 1):
  - A = 15 (-1), B = 1 -> L = 1.
  - A = 7, B = 8 (-8) -> G = 1.
  - A = 8, B = 8 -> E = 1.
- Exhaustive: all 256 (A, B) pairs in both modes -> registered E/G/L match the reference relation one cycle later and are one-hot every cycle.
- Async reset mid-stream: assert rst_n between clock edges during a valid burst -> outputs clear without waiting for a clock edge. The first valid pair after release appears one cycle after capture.

Source files
------------

// File: rtl/comparator_4bit_bf.sv
// Registered E/G/L magnitude comparator built from an MSB-first cascade of per-bit xnor cells.
// SIGNED_CMP flips the MSB decision so two's-complement operands order correctly.

module comparator_4bit_bf_cell (
    input  logic a,
    input  logic b,
    input  logic hi_eq,
    input  logic swap,
    output logic x,
    output logic g,
    output logic l
);
    assign x = ~(a ^ b);
    // A bit decides the result only when every more-significant bit matched.
    assign g = hi_eq & (swap ? (~a & b) : (a & ~b));
    assign l = hi_eq & (swap ? (a & ~b) : (~a & b));
endmodule

module comparator_4bit_bf #(
    parameter int WIDTH      = 4,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             E,
    output logic             G,
    output logic             L
);
    localparam int STAGES = 1;

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] g_t;
    logic [WIDTH-1:0] l_t;
    logic [WIDTH-1:0] hi_eq;
    logic             eq, gt, lt;
    logic [STAGES:1]  vld_pipe;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            if (i == WIDTH - 1) begin : g_msb
                assign hi_eq[i] = 1'b1;
            end else begin : g_low
                assign hi_eq[i] = hi_eq[i+1] & x[i+1];
            end

            comparator_4bit_bf_cell u_cell (
                .a     (A[i]),
                .b     (B[i]),
                .hi_eq (hi_eq[i]),
                .swap  (SIGNED_CMP && (i == WIDTH - 1)),
                .x     (x[i]),
                .g     (g_t[i]),
                .l     (l_t[i])
            );
        end
    endgenerate

    assign eq = &x;
    assign gt = |g_t;
    assign lt = |l_t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            E        <= 1'b0;
            G        <= 1'b0;
            L        <= 1'b0;
        end else begin
            vld_pipe[1] <= in_valid;
            // Flags hold the last captured pair; only out_valid tracks idle cycles.
            if (in_valid) begin
                E <= eq;
                G <= gt;
                L <= lt;
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_comparator_4bit_bf.sv
// Directed and exhaustive checks of the unsigned and signed comparator variants side by side.

module tb_comparator_4bit_bf;
    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic       ov_u, e_u, g_u, l_u;
    logic       ov_s, e_s, g_s, l_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 if (clk_en) clk = ~clk;

    comparator_4bit_bf #(.WIDTH(4), .SIGNED_CMP(1'b0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
        .out_valid(ov_u), .E(e_u), .G(g_u), .L(l_u)
    );

    comparator_4bit_bf #(.WIDTH(4), .SIGNED_CMP(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
        .out_valid(ov_s), .E(e_s), .G(g_s), .L(l_s)
    );

    // Values are packed {out_valid, E, G, L}.
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_egl(input logic [3:0] a, input logic [3:0] b, input bit sgn);
        int ia, ib;
        ia = sgn ? int'($signed(a)) : int'(a);
        ib = sgn ? int'($signed(b)) : int'(b);
        return {1'b1, ia == ib, ia > ib, ia < ib};
    endfunction

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with the clock stopped.
        #3;
        chk("rst_u", {ov_u, e_u, g_u, l_u}, 4'b0000);
        chk("rst_s", {ov_s, e_s, g_s, l_s}, 4'b0000);
        clk_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 4'd5, 4'd3);
        drive(1'b0, 4'd5, 4'd3);
        chk("idle_u", {ov_u, e_u, g_u, l_u}, 4'b0000);
        chk("idle_s", {ov_s, e_s, g_s, l_s}, 4'b0000);

        // Directed unsigned.
        drive(1'b1, 4'd0,  4'd0);  chk("u_0_0",   {ov_u, e_u, g_u, l_u}, 4'b1100);
        drive(1'b1, 4'd11, 4'd7);  chk("u_11_7",  {ov_u, e_u, g_u, l_u}, 4'b1010);
        drive(1'b1, 4'd13, 4'd14); chk("u_13_14", {ov_u, e_u, g_u, l_u}, 4'b1001);
        drive(1'b1, 4'd3,  4'd7);  chk("u_3_7",   {ov_u, e_u, g_u, l_u}, 4'b1001);
        drive(1'b1, 4'd15, 4'd13); chk("u_15_13", {ov_u, e_u, g_u, l_u}, 4'b1010);

        // Hold on idle.
        drive(1'b1, 4'd11, 4'd7);  chk("hold_cap", {ov_u, e_u, g_u, l_u}, 4'b1010);
        drive(1'b0, 4'd2,  4'd9);  chk("hold_u",   {ov_u, e_u, g_u, l_u}, 4'b0010);
        drive(1'b0, 4'd2,  4'd9);  chk("hold_u2",  {ov_u, e_u, g_u, l_u}, 4'b0010);

        // Directed signed, with unsigned view of the same pairs.
        drive(1'b1, 4'd15, 4'd1);
        chk("s_m1_1", {ov_s, e_s, g_s, l_s}, 4'b1001);
        chk("u_15_1", {ov_u, e_u, g_u, l_u}, 4'b1010);
        drive(1'b1, 4'd7, 4'd8);
        chk("s_7_m8", {ov_s, e_s, g_s, l_s}, 4'b1010);
        chk("u_7_8",  {ov_u, e_u, g_u, l_u}, 4'b1001);
        drive(1'b1, 4'd8, 4'd8);
        chk("s_m8_m8", {ov_s, e_s, g_s, l_s}, 4'b1100);
        drive(1'b1, 4'd9, 4'd14);
        chk("s_m7_m2", {ov_s, e_s, g_s, l_s}, 4'b1001);

        // Exhaustive, back to back.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive(1'b1, 4'(a), 4'(b));
                chk($sformatf("ex_u_%0d_%0d", a, b), {ov_u, e_u, g_u, l_u}, ref_egl(4'(a), 4'(b), 1'b0));
                chk($sformatf("ex_s_%0d_%0d", a, b), {ov_s, e_s, g_s, l_s}, ref_egl(4'(a), 4'(b), 1'b1));
                chk("onehot", {2'b00, $onehot({e_u, g_u, l_u}), $onehot({e_s, g_s, l_s})}, 4'b0011);
            end
        end

        // Async reset in the middle of a valid burst.
        drive(1'b1, 4'd12, 4'd4);
        chk("pre_arst", {ov_u, e_u, g_u, l_u}, 4'b1010);
        in_valid = 1'b1; A = 4'd1; B = 4'd2;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_u", {ov_u, e_u, g_u, l_u}, 4'b0000);
        chk("arst_s", {ov_s, e_s, g_s, l_s}, 4'b0000);
        @(posedge clk); #1;
        chk("arst_hold", {ov_u, e_u, g_u, l_u}, 4'b0000);
        #2;
        rst_n = 1'b1;
        drive(1'b1, 4'd6, 4'd6);
        chk("post_arst_u", {ov_u, e_u, g_u, l_u}, 4'b1100);
        chk("post_arst_s", {ov_s, e_s, g_s, l_s}, 4'b1100);
        drive(1'b0, 4'd0, 4'd15);
        chk("post_idle", {ov_u, e_u, g_u, l_u}, 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
